// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU (opcodes 0x10-0x17) with valid/ready on operand and result sides.
// Latency: 1 cycle for add/sub/logic/illegal/div-by-zero, WIDTH+1 cycles for MUL and DIV.
// Backpressure: one op in flight; result held in DONE until out_ready. Optional flags: SEQ_ALU_FLAGS_EN.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h10);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(8'h11);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8'h12);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(8'h13);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(8'h14);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(8'h15);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(8'h16);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(8'h17);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  // MUL: {partial product high, multiplier / product low}. DIV: {remainder, dividend / quotient}.
  logic [2*WIDTH-1:0] r_acc;
  // MUL: multiplicand a. DIV: divisor b.
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_result;
  logic               r_err;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_res;
  logic               w_err;
  logic               w_go_mul;
  logic               w_go_div;
  logic               w_last;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // One shift-add step: add multiplicand into the high half when the low bit is set, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
  // The difference is below the divisor, so its low WIDTH bits are exact.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  // Decode the presented opcode: single-cycle result or dispatch to an iterative unit.
  always_comb begin
    w_res    = '0;
    w_err    = 1'b0;
    w_go_mul = 1'b0;
    w_go_div = 1'b0;
    case (op)
      OP_ADD: w_res = a + b;
      OP_SUB: w_res = a - b;
      OP_MUL: w_go_mul = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          w_res = '1;
          w_err = 1'b1;
        end else begin
          w_go_div = 1'b1;
        end
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      default: w_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0] r_flags;
  logic       w_c;

  // Carry for the single-cycle ops: ADD carry-out shows as a wrapped sum, SUB borrow as a < b.
  always_comb begin
    w_c = 1'b0;
    if (op == OP_ADD)      w_c = (w_res < a);
    else if (op == OP_SUB) w_c = (a < b);
  end

  // Flags {n, c, z} registered alongside the result; forced clear on err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid && !w_go_mul && !w_go_div)
                  r_flags <= w_err ? 3'b000 : {w_res[WIDTH-1], w_c, (w_res == '0)};
        S_MUL:  if (w_last)
                  r_flags <= {w_mul_next[WIDTH-1], |w_mul_next[2*WIDTH-1:WIDTH],
                              (w_mul_next[WIDTH-1:0] == '0)};
        S_DIV:  if (w_last)
                  r_flags <= {w_div_next[WIDTH-1], 1'b0, (w_div_next[WIDTH-1:0] == '0)};
        default: ;
      endcase
    end
  end

  assign flags = r_flags;
`else
  assign flags = 3'b000;
`endif

  // Control FSM: accept in IDLE, iterate in MUL/DIV, hold the result in DONE until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt <= '0;
            r_err <= 1'b0;
            if (w_go_mul) begin
              r_state <= S_MUL;
              r_opnd  <= a;
              r_acc   <= {{WIDTH{1'b0}}, b};
            end else if (w_go_div) begin
              r_state <= S_DIV;
              r_opnd  <= b;
              r_acc   <= {{WIDTH{1'b0}}, a};
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_res;
              r_err       <= w_err;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_result    <= w_mul_next[WIDTH-1:0];
            r_out_valid <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_result    <= w_div_next[WIDTH-1:0];
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu at WIDTH=8 and WIDTH=16.
// Checks results, err, flags and handshake latency; flags expected only when SEQ_ALU_FLAGS_EN is set.
// Result side is consumed with a one-cycle out_ready pulse except where backpressure is exercised.
module tb_seq_alu;

`ifdef SEQ_ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, e8;
  logic [7:0] op8, a8, b8, r8;
  logic [2:0] f8;

  logic        iv16, ir16, ov16, or16, e16;
  logic [7:0]  op16;
  logic [15:0] a16, b16, r16;
  logic [2:0]  f16;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [7:0] op; logic [7:0] a; logic [7:0] b;
    logic [7:0] r;  logic e; logic [2:0] f; logic [7:0] lat;
  } vec8_t;

  typedef struct packed {
    logic [7:0] op; logic [15:0] a; logic [15:0] b;
    logic [15:0] r; logic e; logic [2:0] f; logic [7:0] lat;
  } vec16_t;

  seq_alu #(.WIDTH(8), .OP_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .err(e8), .flags(f8));

  seq_alu #(.WIDTH(16), .OP_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .result(r16), .err(e16), .flags(f16));

  function automatic logic [2:0] fx(input logic [2:0] f);
    return FL ? f : 3'b000;
  endfunction

  // Present one op to dut8, scramble inputs after acceptance, wait for out_valid, consume it.
  task automatic drive8(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic e, output logic [2:0] f, output int lat);
    int guard = 0;
    @(posedge clk); #1;
    while (!ir8 && guard < 100) begin @(posedge clk); #1; guard++; end
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; op8 = 8'h00; a8 = ~a; b8 = 8'h00;
    lat = 1;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    r = r8; e = e8; f = f8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic drive16(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic e, output logic [2:0] f, output int lat);
    int guard = 0;
    @(posedge clk); #1;
    while (!ir16 && guard < 100) begin @(posedge clk); #1; guard++; end
    op16 = op; a16 = a; b16 = b; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; op16 = 8'h00; a16 = ~a; b16 = 16'h0000;
    lat = 1;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    r = r16; e = e16; f = f16;
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({ir8, ov8, r8, e8, f8} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'b000})
      $display("FAIL reset8: got ir=%b ov=%b r=%h e=%b f=%b, want ir=1 ov=0 r=00 e=0 f=000",
               ir8, ov8, r8, e8, f8);
    else n_pass++;
    n_chk++;
    if ({ir16, ov16, r16, e16, f16} !== {1'b1, 1'b0, 16'h0000, 1'b0, 3'b000})
      $display("FAIL reset16: got ir=%b ov=%b r=%h e=%b f=%b, want ir=1 ov=0 r=0000 e=0 f=000",
               ir16, ov16, r16, e16, f16);
    else n_pass++;
    #9 rst_n = 1'b1;
  endtask

  task automatic run_table8(input string name, input vec8_t tv[]);
    logic [7:0] r; logic e; logic [2:0] f; int lat;
    foreach (tv[i]) begin
      drive8(tv[i].op, tv[i].a, tv[i].b, r, e, f, lat);
      n_chk++;
      if ({r, e, f, lat[7:0]} !== {tv[i].r, tv[i].e, fx(tv[i].f), tv[i].lat})
        $display("FAIL %s[%0d] op=%h a=%h b=%h: got r=%h e=%b f=%b lat=%0d, want r=%h e=%b f=%b lat=%0d",
                 name, i, tv[i].op, tv[i].a, tv[i].b, r, e, f, lat,
                 tv[i].r, tv[i].e, fx(tv[i].f), tv[i].lat);
      else n_pass++;
    end
  endtask

  // Single-cycle ops, including wrap, zero result and illegal opcodes at both edges of the map.
  task automatic test_single8();
    vec8_t tv[] = '{
      '{8'h10, 8'hF0, 8'h20, 8'h10, 1'b0, 3'b010, 8'd1},
      '{8'h10, 8'hFF, 8'h01, 8'h00, 1'b0, 3'b011, 8'd1},
      '{8'h11, 8'h05, 8'h07, 8'hFE, 1'b0, 3'b110, 8'd1},
      '{8'h14, 8'hF0, 8'h3C, 8'h30, 1'b0, 3'b000, 8'd1},
      '{8'h15, 8'hF0, 8'h0F, 8'hFF, 1'b0, 3'b100, 8'd1},
      '{8'h16, 8'hAA, 8'hAA, 8'h00, 1'b0, 3'b001, 8'd1},
      '{8'h20, 8'h12, 8'h34, 8'h00, 1'b1, 3'b000, 8'd1},
      '{8'h17, 8'hA5, 8'hFF, 8'h5A, 1'b0, 3'b000, 8'd1},
      '{8'h0F, 8'h01, 8'h01, 8'h00, 1'b1, 3'b000, 8'd1},
      '{8'h18, 8'h01, 8'h01, 8'h00, 1'b1, 3'b000, 8'd1},
      '{8'h11, 8'h07, 8'h05, 8'h02, 1'b0, 3'b000, 8'd1}
    };
    run_table8("single8", tv);
  endtask

  task automatic test_mul8();
    vec8_t tv[] = '{
      '{8'h12, 8'h0F, 8'h11, 8'hFF, 1'b0, 3'b100, 8'd9},
      '{8'h12, 8'h10, 8'h10, 8'h00, 1'b0, 3'b011, 8'd9},
      '{8'h12, 8'hFF, 8'hFF, 8'h01, 1'b0, 3'b010, 8'd9},
      '{8'h12, 8'h07, 8'h06, 8'h2A, 1'b0, 3'b000, 8'd9}
    };
    run_table8("mul8", tv);
  endtask

  task automatic test_div8();
    vec8_t tv[] = '{
      '{8'h13, 8'hC8, 8'h07, 8'h1C, 1'b0, 3'b000, 8'd9},
      '{8'h13, 8'h55, 8'h00, 8'hFF, 1'b1, 3'b000, 8'd1},
      '{8'h13, 8'h07, 8'hC8, 8'h00, 1'b0, 3'b001, 8'd9},
      '{8'h13, 8'hFF, 8'h01, 8'hFF, 1'b0, 3'b100, 8'd9},
      '{8'h13, 8'hFF, 8'hFF, 8'h01, 1'b0, 3'b000, 8'd9}
    };
    run_table8("div8", tv);
  endtask

  // Hold the ADD result for 5 cycles of backpressure while the input side churns.
  task automatic test_backpressure();
    @(posedge clk); #1;
    op8 = 8'h10; a8 = 8'hF0; b8 = 8'h20; iv8 = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({ov8, r8} !== {1'b1, 8'h10})
      $display("FAIL bp_first: got ov=%b r=%h, want ov=1 r=10", ov8, r8);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); iv8 = ~iv8; op8 = 8'h16;
      @(posedge clk); #1;
      n_chk++;
      if ({ov8, ir8, r8, e8, f8} !== {1'b1, 1'b0, 8'h10, 1'b0, fx(3'b010)})
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b r=%h e=%b f=%b, want ov=1 ir=0 r=10 e=0 f=%b",
                 i, ov8, ir8, r8, e8, f8, fx(3'b010));
      else n_pass++;
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    n_chk++;
    if ({ov8, ir8} !== {1'b0, 1'b1})
      $display("FAIL bp_release: got ov=%b ir=%b, want ov=0 ir=1", ov8, ir8);
    else n_pass++;
  endtask

  // Back-to-back ops: after a consume the next op is accepted at once and err clears on accept.
  task automatic test_back_to_back();
    logic [7:0] r; logic e; logic [2:0] f; int lat;
    drive8(8'h13, 8'h10, 8'h00, r, e, f, lat);
    n_chk++;
    if ({ov8, ir8} !== {1'b0, 1'b1})
      $display("FAIL b2b_idle: got ov=%b ir=%b, want ov=0 ir=1", ov8, ir8);
    else n_pass++;
    drive8(8'h10, 8'h01, 8'h02, r, e, f, lat);
    n_chk++;
    if ({r, e, lat[7:0]} !== {8'h03, 1'b0, 8'd1})
      $display("FAIL b2b_next: got r=%h e=%b lat=%0d, want r=03 e=0 lat=1", r, e, lat);
    else n_pass++;
  endtask

  // Abort a MUL mid-iteration with reset; no result may follow, and a later DIV works.
  task automatic test_reset_mid_op();
    logic [7:0] r; logic e; logic [2:0] f; int lat;
    bit seen = 1'b0;
    @(posedge clk); #1;
    op8 = 8'h12; a8 = 8'h0F; b8 = 8'h11; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ov8, ir8, r8} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL rst_mid: got ov=%b ir=%b r=%h, want ov=0 ir=1 r=00", ov8, ir8, r8);
    else n_pass++;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL rst_discard: got out_valid after abort=1, want 0");
    else n_pass++;
    drive8(8'h13, 8'h64, 8'h0A, r, e, f, lat);
    n_chk++;
    if ({r, e, f, lat[7:0]} !== {8'h0A, 1'b0, fx(3'b000), 8'd9})
      $display("FAIL rst_div: got r=%h e=%b f=%b lat=%0d, want r=0a e=0 f=%b lat=9",
               r, e, f, lat, fx(3'b000));
    else n_pass++;
  endtask

  task automatic test_width16();
    logic [15:0] r; logic e; logic [2:0] f; int lat;
    vec16_t tv[] = '{
      '{8'h10, 16'hFFF0, 16'h0020, 16'h0010, 1'b0, 3'b010, 8'd1},
      '{8'h10, 16'h00F0, 16'h0020, 16'h0110, 1'b0, 3'b000, 8'd1},
      '{8'h12, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 3'b100, 8'd17},
      '{8'h12, 16'h0100, 16'h0100, 16'h0000, 1'b0, 3'b011, 8'd17},
      '{8'h13, 16'h00C8, 16'h0007, 16'h001C, 1'b0, 3'b000, 8'd17},
      '{8'h13, 16'h0055, 16'h0000, 16'hFFFF, 1'b1, 3'b000, 8'd1},
      '{8'h13, 16'hFFFF, 16'h0003, 16'h5555, 1'b0, 3'b000, 8'd17}
    };
    foreach (tv[i]) begin
      drive16(tv[i].op, tv[i].a, tv[i].b, r, e, f, lat);
      n_chk++;
      if ({r, e, f, lat[7:0]} !== {tv[i].r, tv[i].e, fx(tv[i].f), tv[i].lat})
        $display("FAIL w16[%0d] op=%h a=%h b=%h: got r=%h e=%b f=%b lat=%0d, want r=%h e=%b f=%b lat=%0d",
                 i, tv[i].op, tv[i].a, tv[i].b, r, e, f, lat,
                 tv[i].r, tv[i].e, fx(tv[i].f), tv[i].lat);
      else n_pass++;
    end
  endtask

  initial begin
    iv8 = 1'b0; or8 = 1'b0; op8 = 8'h00; a8 = 8'h00; b8 = 8'h00;
    iv16 = 1'b0; or16 = 1'b0; op16 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
    test_reset();
    test_single8();
    test_mul8();
    test_div8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the core's combinational ALU.
- Keeps the same opcode map (0x10–0x17) and runs at any WIDTH.
- Replaces the edge-triggered enable with a valid/ready handshake on both the operand and result sides.
- Multiply and divide are iterative (one bit per cycle); all other ops complete in one cycle.
- Sits between the CPU control FSM and the register file.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)
OP_W, 8, opcode width; opcodes compared on the full OP_W bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode presented
in_ready  output  1  block can accept an operation
op  input  OP_W  opcode
a  input  WIDTH  operand r1
b  input  WIDTH  operand r2
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
err  output  1  illegal opcode or divide by zero
flags  output  3  {n, c, z}; see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, err=0, flags=0. Internal counters and accumulators clear.
- States: IDLE, MUL, DIV, DONE.
- Reset mid-operation: the operation is aborted and discarded; no result is produced.
- in_ready = (state==IDLE). No overlap: one operation in flight.
- Accept on in_valid && in_ready. a, b and op are captured at acceptance; later input changes are ignored.
- Single-cycle ops: IDLE→DONE. out_valid rises the cycle after acceptance (latency 1).
  - 0x10 ADD: a+b mod 2^WIDTH.
  - 0x11 SUB: a−b mod 2^WIDTH.
  - 0x14 AND, 0x15 OR, 0x16 XOR: bitwise.
  - 0x17 NOT: ~a; b is ignored.
- 0x12 MUL: IDLE→MUL.
  - Unsigned shift-add, WIDTH iterations.
  - Then →DONE, so out_valid rises WIDTH+1 cycles after acceptance.
  - result = low WIDTH bits of the 2·WIDTH product.
- 0x13 DIV: IDLE→DIV.
  - Unsigned restoring division, WIDTH iterations, same latency as MUL.
  - result = quotient; remainder is discarded.
  - b==0: skip DIV and go →DONE directly (latency 1). result = all-ones, err=1.
- Illegal opcode (outside 0x10–0x17): →DONE, latency 1. result=0, err=1.
- DONE:
  - out_valid=1; result, err and flags are held stable until out_ready.
  - On out_valid && out_ready: →IDLE, out_valid drops, and in_ready rises in the following cycle.
  - Result is not lost under backpressure of any length.
- err clears when the next operation is accepted.
- The iteration counter is ceil(log2(WIDTH+1)) bits wide. No counter wrap is permitted before WIDTH iterations complete.

Optional Feature:
Macro: SEQ_ALU_FLAGS_EN
- Defined: flags are registered with result. All flags clear on err.
  - z = (result==0).
  - n = result[WIDTH-1].
  - c depends on op:
    - ADD: carry-out.
    - SUB: borrow (a<b).
    - MUL: any nonzero bit in the upper WIDTH product bits.
    - DIV and logic ops: 0.
- Not defined: flags tied to 3'b000. No flag logic or registers are synthesised. Port list is unchanged.

Test Plan:
1. WIDTH=8, ADD a=0xF0 b=0x20 → result=0x10, out_valid exactly 1 cycle after accept; with flags: c=1 z=0 n=0.
2. MUL a=0x0F b=0x11 → 0xFF, c=0, out_valid 9 cycles after accept. MUL 0x10×0x10 → 0x00, c=1 z=1.
3. DIV a=0xC8 b=0x07 → 0x1C, latency 9. DIV a=0x55 b=0x00 → 0xFF, err=1, latency 1.
4. SUB 0x05−0x07 → 0xFE, c=1 n=1. Illegal op 0x20 → result=0, err=1, flags=0. NOT a=0xA5 → 0x5A.
5. Backpressure: hold out_ready=0 for 5 cycles after ADD completes; toggle a/b/in_valid meanwhile. Required: result stable, in_ready=0, no new accept. Result consumed on out_ready=1, in_ready=1 the next cycle.
6. Pulse rst_n low during MUL iteration 4 → out_valid=0, in_ready=1 immediately. A following DIV 0x64/0x0A → 0x0A. Repeat tests 1–3 at WIDTH=16 (MUL 0x00FF×0x0101 → 0xFFFF, latency 17).
